// File: rtl/router_pkg.sv
// Shared router definitions: flit geometry, VC buffer state and hop-field helper.
package router_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int HOP_MSB    = 55;
  localparam int HOP_LSB    = 48;

  typedef enum logic {
    VC_EMPTY = 1'b0,
    VC_FULL  = 1'b1
  } vc_state_t;

  // Thermometer hop count: one hop consumed == shift right by one. Zero stays zero.
  function automatic logic [DATA_WIDTH-1:0] hop_dec(input logic [DATA_WIDTH-1:0] flit);
    logic [DATA_WIDTH-1:0] f;
    f = flit;
    f[HOP_MSB:HOP_LSB] = flit[HOP_MSB:HOP_LSB] >> 1;
    return f;
  endfunction

endpackage

// File: rtl/vc_link_arbiter_rr_picker.sv
// rr_picker: combinational round-robin search. Returns the first requester
// strictly after i_ptr (cyclically), as one-hot and as an index.
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int PW      = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [PW-1:0]      o_idx,
  output logic               o_any
);

  logic [PW-1:0] w_idx;

  // Walk offsets 1..NUM_REQ from the pointer; the first set request wins.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = PW'((int'(i_ptr) + k) % NUM_REQ);
      if (!o_any && i_req[w_idx]) begin
        o_any        = 1'b1;
        o_gnt[w_idx] = 1'b1;
        o_idx        = w_idx;
      end
    end
  end

endmodule

// File: rtl/vc_link_arbiter.sv
// vc_link_arbiter: two-VC round-robin scheduler onto one polarity-multiplexed
// ring link. Each VC holds one flit; the hop field is decremented on egress.
// Optional per-requester grant counters are built when ARB_GRANT_CNT_EN is defined.
// Handshake: req is a level held by the requester; a 1-cycle gnt pulse the cycle
// after sampling means the flit was taken and req must drop or advance. out_valid
// is a 1-cycle strobe issued only when out_ready was high at the sending edge.
module vc_link_arbiter
  import router_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            polarity,
  input  logic [NUM_REQ-1:0]              req_even,
  input  logic [NUM_REQ-1:0]              req_odd,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   data_in_even,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   data_in_odd,
  output logic [NUM_REQ-1:0]              gnt_even,
  output logic [NUM_REQ-1:0]              gnt_odd,
  input  logic                            out_ready,
  output logic                            out_valid,
  output logic [DATA_WIDTH-1:0]           out_data,
`ifdef ARB_GRANT_CNT_EN
  output logic [NUM_REQ*CNT_WIDTH-1:0]    grant_cnt,
`endif
  output logic                            o_state_even,
  output logic                            o_state_odd
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Index 0 = even VC, 1 = odd VC.
  vc_state_t               r_state [2];
  logic [PW-1:0]           r_ptr   [2];
  logic [DATA_WIDTH-1:0]   r_buf   [2];
  logic [NUM_REQ-1:0]      r_gnt   [2];
  logic                    r_out_valid;
  logic [DATA_WIDTH-1:0]   r_out_data;

  logic [NUM_REQ-1:0]      w_pick  [2];
  logic [PW-1:0]           w_idx   [2];
  logic                    w_any   [2];
  logic [DATA_WIDTH-1:0]   w_sel   [2];
  logic                    w_pol_match [2];

  rr_picker #(.NUM_REQ(NUM_REQ), .PW(PW)) u_pick_even (
    .i_req (req_even),
    .i_ptr (r_ptr[0]),
    .o_gnt (w_pick[0]),
    .o_idx (w_idx[0]),
    .o_any (w_any[0])
  );

  rr_picker #(.NUM_REQ(NUM_REQ), .PW(PW)) u_pick_odd (
    .i_req (req_odd),
    .i_ptr (r_ptr[1]),
    .o_gnt (w_pick[1]),
    .o_idx (w_idx[1]),
    .o_any (w_any[1])
  );

  assign w_sel[0]       = data_in_even[w_idx[0]*DATA_WIDTH +: DATA_WIDTH];
  assign w_sel[1]       = data_in_odd[w_idx[1]*DATA_WIDTH +: DATA_WIDTH];
  assign w_pol_match[0] = ~polarity;
  assign w_pol_match[1] = polarity;

  // Per-VC EMPTY/FULL FSMs plus the shared link output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      for (int v = 0; v < 2; v++) begin
        r_state[v] <= VC_EMPTY;
        r_ptr[v]   <= PW'(NUM_REQ - 1);
        r_buf[v]   <= '0;
        r_gnt[v]   <= '0;
      end
    end else begin
      r_out_valid <= 1'b0;
      for (int v = 0; v < 2; v++) begin
        r_gnt[v] <= '0;
        case (r_state[v])
          VC_EMPTY: begin
            if (w_any[v]) begin
              r_buf[v]   <= w_sel[v];
              r_gnt[v]   <= w_pick[v];
              r_ptr[v]   <= w_idx[v];
              r_state[v] <= VC_FULL;
            end
          end
          VC_FULL: begin
            // Polarities are exclusive, so at most one VC reaches this send.
            if (w_pol_match[v] && out_ready) begin
              r_out_valid <= 1'b1;
              r_out_data  <= hop_dec(r_buf[v]);
              r_state[v]  <= VC_EMPTY;
            end
          end
          default: r_state[v] <= VC_EMPTY;
        endcase
      end
    end
  end

  assign gnt_even     = r_gnt[0];
  assign gnt_odd      = r_gnt[1];
  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign o_state_even = r_state[0];
  assign o_state_odd  = r_state[1];

`ifdef ARB_GRANT_CNT_EN
  logic [CNT_WIDTH-1:0] r_cnt  [NUM_REQ];
  logic [CNT_WIDTH+1:0] w_sum  [NUM_REQ];

  // Grants to one requester from both VCs add together; clamp at all-ones.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sum[i] = {2'b00, r_cnt[i]} + (CNT_WIDTH+2)'(r_gnt[0][i]) + (CNT_WIDTH+2)'(r_gnt[1][i]);
    end
  end

  // Saturating grant counters.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rst)
        r_cnt[i] <= '0;
      else if (w_sum[i] > {2'b00, {CNT_WIDTH{1'b1}}})
        r_cnt[i] <= '1;
      else
        r_cnt[i] <= w_sum[i][CNT_WIDTH-1:0];
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
    assign grant_cnt[g*CNT_WIDTH +: CNT_WIDTH] = r_cnt[g];
  end
`endif

endmodule
